// File: rtl/register_bank_arbiter_pkg.sv
// Shared types for the register bank arbiter: FSM states and the response record.
package register_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // The response record is sized by this constant; the top's DATA_WIDTH defaults to it.
  localparam int BANK_DATA_WIDTH = 8;

  typedef struct packed {
    logic [BANK_DATA_WIDTH-1:0] rdata;
    logic                       err;
  } resp_t;

endpackage

// File: rtl/register_bank_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, with wrap.
module rr_picker #(
  parameter  int NUM_REQ   = 4,
  localparam int REQ_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [REQ_WIDTH-1:0] i_rr_ptr,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [REQ_WIDTH-1:0] o_idx,
  output logic                 o_any_valid
);

  always_comb begin
    int                   cand;
    logic [REQ_WIDTH-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    o_grant     = '0;
    o_idx       = '0;
    o_any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(i_rr_ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = REQ_WIDTH'(cand);
      if (!o_any_valid && i_req[cand_idx]) begin
        o_any_valid       = 1'b1;
        o_grant[cand_idx] = 1'b1;
        o_idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/register_bank_arbiter.sv
// Round-robin sequencer sharing one single-port register bank among NUM_REQ requesters,
// one transaction in flight at a time (IDLE -> ACCESS -> RESP).
module register_bank_arbiter
  import register_bank_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH   = BANK_DATA_WIDTH,
  parameter  int NUM_REG      = 6,
  parameter  int NUM_REQ      = 4,
  localparam int SELECT_WIDTH = $clog2(NUM_REG),
  localparam int REQ_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    i_req_valid,
  input  logic [NUM_REQ-1:0]                    i_req_write,
  input  logic [NUM_REQ-1:0][SELECT_WIDTH-1:0]  i_req_select,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    i_req_wdata,
  output logic [NUM_REQ-1:0]                    o_req_ready,
  output logic [NUM_REQ-1:0]                    o_resp_valid,
  input  logic [NUM_REQ-1:0]                    i_resp_ready,
  output logic [DATA_WIDTH-1:0]                 o_resp_rdata,
  output logic                                  o_resp_err,
  output logic                                  o_bank_write_enable,
  output logic [SELECT_WIDTH-1:0]               o_bank_select,
  output logic [DATA_WIDTH-1:0]                 o_bank_write_data,
  input  logic [DATA_WIDTH-1:0]                 i_bank_read_data,
  output state_t                                o_dbg_state,
  output logic [REQ_WIDTH-1:0]                  o_dbg_rr_ptr
);

  // Handshake: a command transfers on a rising edge where i_req_valid[k] and o_req_ready[k]
  // are both high; a response transfers where o_resp_valid[k] and i_resp_ready[k] are both high.

  state_t                  state_q, state_d;
  logic [REQ_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [REQ_WIDTH-1:0]    cmd_idx_q, cmd_idx_d;
  logic                    cmd_write_q, cmd_write_d;
  logic [SELECT_WIDTH-1:0] cmd_select_q, cmd_select_d;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
  resp_t                   resp_q, resp_d;
  logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic                    we_q, we_d;

  logic [NUM_REQ-1:0]      pick_grant;
  logic [REQ_WIDTH-1:0]    pick_idx;
  logic                    pick_any;

  function automatic logic sel_in_range(input logic [SELECT_WIDTH-1:0] sel);
    return int'(sel) < NUM_REG;
  endfunction

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req       (i_req_valid),
    .i_rr_ptr    (rr_ptr_q),
    .o_grant     (pick_grant),
    .o_idx       (pick_idx),
    .o_any_valid (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cmd_idx_d    = cmd_idx_q;
    cmd_write_d  = cmd_write_q;
    cmd_select_d = cmd_select_q;
    cmd_wdata_d  = cmd_wdata_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    we_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          cmd_idx_d    = pick_idx;
          cmd_write_d  = i_req_write[pick_idx];
          cmd_select_d = i_req_select[pick_idx];
          cmd_wdata_d  = i_req_wdata[pick_idx];
          rr_ptr_d     = (pick_idx == REQ_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + REQ_WIDTH'(1);
          // Write strobe is registered so it is high for exactly the ACCESS cycle.
          we_d         = i_req_write[pick_idx] && sel_in_range(i_req_select[pick_idx]);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (!sel_in_range(cmd_select_q)) begin
          resp_d.rdata = '0;
          resp_d.err   = 1'b1;
        end else if (cmd_write_q) begin
          resp_d.rdata = cmd_wdata_q;
          resp_d.err   = 1'b0;
        end else begin
          resp_d.rdata = i_bank_read_data;
          resp_d.err   = 1'b0;
        end
        resp_valid_d            = '0;
        resp_valid_d[cmd_idx_q] = 1'b1;
        state_d                 = RESP;
      end
      RESP: begin
        if (i_resp_ready[cmd_idx_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cmd_idx_q    <= '0;
      cmd_write_q  <= 1'b0;
      cmd_select_q <= '0;
      cmd_wdata_q  <= '0;
      resp_q       <= '0;
      resp_valid_q <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cmd_idx_q    <= cmd_idx_d;
      cmd_write_q  <= cmd_write_d;
      cmd_select_q <= cmd_select_d;
      cmd_wdata_q  <= cmd_wdata_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      we_q         <= we_d;
    end
  end

  // Ready is the only combinational output; it is held low while reset is asserted.
  assign o_req_ready         = (state_q == IDLE && !rst) ? pick_grant : '0;
  assign o_resp_valid        = resp_valid_q;
  assign o_resp_rdata        = resp_q.rdata;
  assign o_resp_err          = resp_q.err;
  assign o_bank_write_enable = we_q;
  assign o_bank_select       = cmd_select_q;
  assign o_bank_write_data   = cmd_wdata_q;
  assign o_dbg_state         = state_q;
  assign o_dbg_rr_ptr        = rr_ptr_q;

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Self-checking bench for register_bank_arbiter: transaction-level model, bank model,
// directed scenarios and a randomized phase.
module tb_register_bank_arbiter;
  import register_bank_arbiter_pkg::*;

  localparam int DW   = 8;
  localparam int NREG = 6;
  localparam int NREQ = 4;
  localparam int SW   = 3;
  localparam int RW   = 2;
  localparam int SB_W = RW + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]         req_valid  = '0;
  logic [NREQ-1:0]         req_write  = '0;
  logic [NREQ-1:0][SW-1:0] req_select = '0;
  logic [NREQ-1:0][DW-1:0] req_wdata  = '0;
  logic [NREQ-1:0]         resp_ready = '0;
  logic [NREQ-1:0]         req_ready, resp_valid;
  logic [DW-1:0]           resp_rdata, bank_wdata, bank_rdata;
  logic                    resp_err, bank_we;
  logic [SW-1:0]           bank_sel;
  state_t                  dbg_state;
  logic [RW-1:0]           dbg_rr;

  register_bank_arbiter #(.DATA_WIDTH(DW), .NUM_REG(NREG), .NUM_REQ(NREQ)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_req_valid         (req_valid),
    .i_req_write         (req_write),
    .i_req_select        (req_select),
    .i_req_wdata         (req_wdata),
    .o_req_ready         (req_ready),
    .o_resp_valid        (resp_valid),
    .i_resp_ready        (resp_ready),
    .o_resp_rdata        (resp_rdata),
    .o_resp_err          (resp_err),
    .o_bank_write_enable (bank_we),
    .o_bank_select       (bank_sel),
    .o_bank_write_data   (bank_wdata),
    .i_bank_read_data    (bank_rdata),
    .o_dbg_state         (dbg_state),
    .o_dbg_rr_ptr        (dbg_rr)
  );

  // Register bank attached by the parent: combinational read, cleared by reset.
  logic [DW-1:0] bank_mem [NREG];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) bank_mem[i] <= '0;
    end else if (bank_we && int'(bank_sel) < NREG) begin
      bank_mem[bank_sel] <= bank_wdata;
    end
  end
  assign bank_rdata = (int'(bank_sel) < NREG) ? bank_mem[bank_sel] : '0;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [SB_W-1:0] exp_q[$];
  logic            m_busy = 1'b0;
  int              m_k    = 0;
  logic            m_write;
  logic [SW-1:0]   m_sel;
  logic [DW-1:0]   m_wdata;
  int              m_cyc  = 0;
  int              m_rr   = 0;
  logic [DW-1:0]   m_mem [NREG];

  int            dut_grant_q[$];
  int            we_cycles    = 0;
  logic [SW-1:0] last_we_sel  = '0;
  int            grant1_cnt   = 0;
  int            resp1_cycles = 0;

  // Compare process: once per cycle at the falling edge, predict outputs from the
  // transaction model, compare, then advance the model to the next rising edge.
  initial begin
    int              win;
    logic [NREQ-1:0] e_ready, e_rv;
    logic            e_we, e_err;
    logic [DW-1:0]   e_rdata;
    logic [SB_W-1:0] front;
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 1'b0;
        m_rr   = 0;
        m_cyc  = 0;
        exp_q.delete();
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_bank_we", bank_we, 0);
        check("rst_bank_sel", bank_sel, 0);
        check("rst_bank_wdata", bank_wdata, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
      end else begin
        e_ready = '0;
        e_rv    = '0;
        e_we    = 1'b0;
        win     = -1;
        if (!m_busy) begin
          for (int i = 0; i < NREQ; i++) begin
            if (win < 0 && req_valid[(m_rr + i) % NREQ]) win = (m_rr + i) % NREQ;
          end
          if (win >= 0) e_ready[win] = 1'b1;
        end else if (m_cyc == 1) begin
          e_we = m_write && (int'(m_sel) < NREG);
        end else begin
          e_rv[m_k] = 1'b1;
        end
        check("req_ready", req_ready, e_ready);
        check("bank_we", bank_we, e_we);
        check("resp_valid", resp_valid, e_rv);
        if (m_busy && m_cyc == 1) begin
          check("bank_select", bank_sel, m_sel);
          check("bank_wdata", bank_wdata, m_wdata);
        end
        if (m_busy && m_cyc >= 2) begin
          check("sb_nonempty", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            front = exp_q[0];
            check("resp_rdata", resp_rdata, front[DW-1:0]);
            check("resp_err", resp_err, front[DW]);
          end
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_grant_q.push_back(i);
        if (bank_we) begin
          we_cycles++;
          last_we_sel = bank_sel;
        end
        if (req_ready[1]) grant1_cnt++;
        if (resp_valid[1]) resp1_cycles++;
        // advance to the next rising edge
        if (!m_busy) begin
          if (win >= 0) begin
            m_busy  = 1'b1;
            m_k     = win;
            m_write = req_write[win];
            m_sel   = req_select[win];
            m_wdata = req_wdata[win];
            m_cyc   = 1;
            m_rr    = (win + 1) % NREQ;
            e_err   = !(int'(m_sel) < NREG);
            e_rdata = e_err ? '0 : (m_write ? m_wdata : m_mem[m_sel]);
            if (m_write && !e_err) m_mem[m_sel] = m_wdata;
            exp_q.push_back({RW'(win), e_err, e_rdata});
          end
        end else if (m_cyc == 1) begin
          m_cyc = 2;
        end else if (resp_ready[m_k]) begin
          m_busy = 1'b0;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", req_ready[k], 1);
  endtask

  task automatic wait_resp(input int k, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid[k] && lat < 50);
    check("resp_timeout", resp_valid[k], 1);
  endtask

  // One command from requester k with the response consumed immediately.
  task automatic txn(input int k, input bit wr, input int sel, input int wd,
                     output logic [DW-1:0] rd, output logic er, output int lat);
    @(posedge clk); #1;
    req_valid[k]  = 1'b1;
    req_write[k]  = wr;
    req_select[k] = SW'(sel);
    req_wdata[k]  = DW'(wd);
    resp_ready[k] = 1'b1;
    wait_ready(k);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    wait_resp(k, lat);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
  endtask

  // Randomized requesters: hold payload until accepted, occasionally withdraw.
  bit rand_on = 1'b0;
  initial begin
    logic [NREQ-1:0] acc;
    wait (rand_on);
    while (rand_on) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk); #1;
      if (!rand_on) break;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && acc[i]) begin
          req_valid[i] = 1'b0;
        end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]  = 1'b1;
          req_write[i]  = 1'($urandom_range(0, 1));
          req_select[i] = SW'($urandom_range(0, 7));
          req_wdata[i]  = DW'($urandom_range(0, 255));
        end
        resp_ready[i] = ($urandom_range(0, 9) < 7);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] rd;
    logic          er;
    int            lat, w0, g0, r0, n;
    int            rr_exp [5] = '{0, 1, 2, 3, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state_idle", dbg_state, IDLE);
    check("reset_rr_ptr", dbg_rr, 0);
    rst = 1'b0;

    // Round robin with all requesters continuously valid.
    @(posedge clk); #1;
    dut_grant_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]  = 1'b1;
      req_write[i]  = 1'b1;
      req_select[i] = SW'(i);
      req_wdata[i]  = DW'(8'h10 + i);
    end
    resp_ready = '1;
    n = 0;
    while (dut_grant_q.size() < 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    resp_ready = '0;
    check("rr_grant_count", dut_grant_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (dut_grant_q.size() > i) check("rr_grant_order", dut_grant_q[i], rr_exp[i]);
    end
    for (int i = 0; i < NREQ; i++) begin
      txn(i, 1'b0, i, 0, rd, er, lat);
      check("rr_reg_value", rd, 8'h10 + i);
      check("rr_reg_err", er, 0);
    end

    // Single write then read.
    w0 = we_cycles;
    txn(0, 1'b1, 2, 8'hAA, rd, er, lat);
    check("wr_latency", lat, 2);
    check("wr_rdata", rd, 8'hAA);
    check("wr_err", er, 0);
    check("wr_we_cycles", we_cycles - w0, 1);
    check("wr_we_select", last_we_sel, 2);
    w0 = we_cycles;
    txn(0, 1'b0, 2, 0, rd, er, lat);
    check("rd_latency", lat, 2);
    check("rd_rdata", rd, 8'hAA);
    check("rd_err", er, 0);
    check("rd_we_cycles", we_cycles - w0, 0);

    // Out-of-range select.
    w0 = we_cycles;
    txn(1, 1'b1, 7, 8'hCC, rd, er, lat);
    check("oor_wr_err", er, 1);
    check("oor_wr_rdata", rd, 0);
    check("oor_we_cycles", we_cycles - w0, 0);
    txn(1, 1'b0, 7, 0, rd, er, lat);
    check("oor_rd_err", er, 1);
    check("oor_rd_rdata", rd, 0);
    txn(1, 1'b0, 2, 0, rd, er, lat);
    check("oor_reg2_kept", rd, 8'hAA);

    // Response backpressure with req3 waiting.
    txn(2, 1'b1, 1, 8'hBB, rd, er, lat);
    @(posedge clk); #1;
    req_valid[2]  = 1'b1;
    req_write[2]  = 1'b0;
    req_select[2] = SW'(1);
    resp_ready[2] = 1'b0;
    wait_ready(2);
    @(posedge clk); #1;
    req_valid[2]  = 1'b0;
    req_valid[3]  = 1'b1;
    req_write[3]  = 1'b1;
    req_select[3] = SW'(5);
    req_wdata[3]  = 8'h33;
    resp_ready[3] = 1'b1;
    wait_resp(2, lat);
    for (int h = 0; h < 5; h++) begin
      if (h > 0) @(negedge clk);
      check("bp_resp_valid", resp_valid[2], 1);
      check("bp_rdata", resp_rdata, 8'hBB);
      check("bp_req3_blocked", req_ready[3], 0);
    end
    @(posedge clk); #1;
    resp_ready[2] = 1'b1;
    @(negedge clk);
    check("bp_req3_still_blocked", req_ready[3], 0);
    @(posedge clk); #1;
    resp_ready[2] = 1'b0;
    @(negedge clk);
    check("bp_req3_granted", req_ready[3], 1);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_resp(3, lat);
    check("bp_req3_rdata", resp_rdata, 8'h33);
    @(posedge clk); #1;
    resp_ready[3] = 1'b0;

    // Valid withdrawal by req1 while req0 is busy.
    g0 = grant1_cnt;
    r0 = resp1_cycles;
    @(posedge clk); #1;
    req_valid[0]  = 1'b1;
    req_write[0]  = 1'b0;
    req_select[0] = SW'(0);
    resp_ready[0] = 1'b0;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0]  = 1'b0;
    req_valid[1]  = 1'b1;
    req_write[1]  = 1'b1;
    req_select[1] = SW'(3);
    req_wdata[1]  = 8'h77;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("wd_req1_no_grant", grant1_cnt - g0, 0);
    check("wd_req1_no_resp", resp1_cycles - r0, 0);
    txn(2, 1'b0, 3, 0, rd, er, lat);
    check("wd_reg3_kept", rd, 8'h13);

    // Reset while a write is in ACCESS.
    @(posedge clk); #1;
    req_valid[0]  = 1'b1;
    req_write[0]  = 1'b1;
    req_select[0] = SW'(4);
    req_wdata[0]  = 8'h55;
    resp_ready[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("ra_we_in_access", bank_we, 1);
    check("ra_state_access", dbg_state, ACCESS);
    #1;
    rst = 1'b1;
    #1;
    check("ra_we_dropped", bank_we, 0);
    check("ra_resp_valid", resp_valid, 0);
    check("ra_req_ready", req_ready, 0);
    check("ra_bank_sel", bank_sel, 0);
    check("ra_bank_wdata", bank_wdata, 0);
    check("ra_state_idle", dbg_state, IDLE);
    check("ra_rr_ptr", dbg_rr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("ra_no_resp", resp_valid, 0);
    txn(0, 1'b0, 4, 0, rd, er, lat);
    check("ra_reg4_cleared", rd, 0);
    resp_ready = '0;

    // Randomized traffic checked cycle by cycle against the model.
    rand_on = 1'b1;
    repeat (3000) @(posedge clk);
    rand_on = 1'b0;
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = '1;
    repeat (6) @(posedge clk);
    #1;
    check("drain_idle", dbg_state, IDLE);
    check("drain_no_resp", resp_valid, 0);
    resp_ready = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
